// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// decoded Booth digit, and the digit-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude is 0 when neither one nor two is set; neg selects invert+carry.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } digit_t;

  // Unsigned operands need one extra digit to absorb the implicit zero MSBs.
  function automatic int unsigned n_digits(input int unsigned width, input logic sgn);
    return sgn ? (width / 2) : (width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_digit_dec.sv
// Radix-4 Booth window decoder: {b[2i+1], b[2i], b[2i-1]} -> digit in {-2..+2}.
module booth_digit_dec
  import booth_pkg::*;
(
  input  logic [2:0] win_i,
  output digit_t     dig_o
);

  always_comb begin
    dig_o = '0;
    case (win_i)
      3'b001, 3'b010: dig_o.one = 1'b1;
      3'b011:         dig_o.two = 1'b1;
      3'b100: begin
        dig_o.neg = 1'b1;
        dig_o.two = 1'b1;
      end
      3'b101, 3'b110: begin
        dig_o.neg = 1'b1;
        dig_o.one = 1'b1;
      end
      default: dig_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per BUSY cycle, LSB-first.
// Define BOOTH_MUL_ACC_EN to add the in_acc port and an ACC_W-bit accumulator.
module booth_mul_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH + 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BOOTH_MUL_ACC_EN
  input  logic                 in_acc,
  output logic [ACC_W-1:0]     out_data
`else
  output logic [2*WIDTH-1:0]   out_data
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 3;
  localparam int CW = $clog2(WIDTH / 2 + 2);

  if ((WIDTH % 2) != 0 || WIDTH < 4 || ACC_W < 2 * WIDTH) begin : g_param_err
    $error("booth_mul_seq: WIDTH must be even and >= 4, ACC_W >= 2*WIDTH");
  end

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   prod_q;
  logic [PW-1:0]   mcand_q;
  logic [MW-1:0]   mplr_q;
  logic            sgn_q;
  logic            in_ready_q;
  logic            out_valid_q;
`ifdef BOOTH_MUL_ACC_EN
  logic            acc_req_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] prod_ext;
`else
  logic [PW-1:0]   out_data_q;
`endif

  digit_t          dig;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   prod_d;
  logic [CW-1:0]   last_cnt;

  booth_digit_dec u_dec (
    .win_i (mplr_q[2:0]),
    .dig_o (dig)
  );

  // Negative digits invert the partial product and inject the +1 as carry-in
  // of the single accumulate adder.
  always_comb begin
    pp = '0;
    if (dig.two)      pp = {mcand_q[PW-2:0], 1'b0};
    else if (dig.one) pp = mcand_q;
    prod_d   = prod_q + (pp ^ {PW{dig.neg}}) + PW'(dig.neg);
    last_cnt = CW'(n_digits(WIDTH, sgn_q) - 1);
  end

`ifdef BOOTH_MUL_ACC_EN
  always_comb begin
    prod_ext = sgn_q ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      sgn_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef BOOTH_MUL_ACC_EN
      acc_req_q   <= 1'b0;
      acc_q       <= '0;
`else
      out_data_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};
            mplr_q     <= {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
            sgn_q      <= in_signed;
`ifdef BOOTH_MUL_ACC_EN
            acc_req_q  <= in_acc;
`endif
            prod_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          prod_q  <= prod_d;
          mcand_q <= {mcand_q[PW-3:0], 2'b00};
          mplr_q  <= {2'b00, mplr_q[MW-1:2]};
          if (cnt_q == last_cnt) state_q <= DONE;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        DONE: begin
          // First DONE cycle registers the result; later cycles hold it.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
`ifdef BOOTH_MUL_ACC_EN
            acc_q <= acc_req_q ? (acc_q + prod_ext) : prod_ext;
`else
            out_data_q <= prod_q;
`endif
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
`ifdef BOOTH_MUL_ACC_EN
  assign out_data  = acc_q;
`else
  assign out_data  = out_data_q;
`endif

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq (WIDTH=8); BOOTH_MUL_ACC_EN adds the accumulate test.
module tb_booth_mul_seq;

`ifdef BOOTH_MUL_ACC_EN
  localparam int OUT_W = 24;
`else
  localparam int OUT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef BOOTH_MUL_ACC_EN
  logic             in_acc;
`endif

  int unsigned total  = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BOOTH_MUL_ACC_EN
    .in_acc    (in_acc),
`endif
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Expected out_data for a 16-bit product; the accumulator view extends it.
  function automatic logic [63:0] xp(input logic [15:0] p, input bit s);
    logic [63:0] v;
    v = s ? {{48{p[15]}}, p} : {48'b0, p};
    return v & ((64'd1 << OUT_W) - 64'd1);
  endfunction

  task automatic start(input logic [7:0] a, input logic [7:0] b, input bit s);
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    chk("in_ready_before_accept", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit s, input logic [15:0] p, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    start(a, b, s);
    chk({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
    wait_valid(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_data"}, 64'(out_data), xp(p, s));
    @(posedge clk);
    #1;
    chk({tag, "_popped"}, {out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
`ifdef BOOTH_MUL_ACC_EN
    in_acc    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("s_min_min", 8'h80, 8'h80, 1'b1, 16'h4000, 5);
    run_op("u_max_max", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 6);
    run_op("s_zero_a",  8'h00, 8'hFB, 1'b1, 16'h0000, 5);
    run_op("u_zero_b",  8'hC3, 8'h00, 1'b0, 16'h0000, 6);
    run_op("s_m1_m1",   8'hFF, 8'hFF, 1'b1, 16'h0001, 5);
    run_op("s_max_min", 8'h7F, 8'h80, 1'b1, 16'hC080, 5);
    run_op("u_200_3",   8'hC8, 8'h03, 1'b0, 16'h0258, 6);
    run_op("s_1_min",   8'h01, 8'h80, 1'b1, 16'hFF80, 5);

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    start(8'hFD, 8'h07, 1'b1);
    wait_valid(lat);
    chk("hold_latency", 64'(lat), 64'd5);
    chk("hold_data_first", 64'(out_data), xp(16'hFFEB, 1'b1));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), xp(16'hFFEB, 1'b1));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", {out_valid, in_ready}, 64'b01);

    // New operands offered mid-operation must be ignored.
    start(8'd5, 8'd6, 1'b0);
    @(negedge clk);
    in_a      = 8'd100;
    in_b      = 8'd100;
    in_signed = 1'b1;
    in_valid  = 1'b1;
    chk("ignore_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("ignore_latency", 64'(lat + 1), 64'd6);
    chk("ignore_data", 64'(out_data), xp(16'd30, 1'b0));
    @(posedge clk);
    #1;

    // Reset during digit 2 aborts with no result.
    start(8'd7, 8'd9, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

`ifdef BOOTH_MUL_ACC_EN
    in_acc = 1'b0;
    run_op("acc_load", 8'd3, 8'd4, 1'b0, 16'd12, 6);
    in_acc = 1'b1;
    run_op("acc_add", 8'd5, 8'd6, 1'b0, 16'd42, 6);
    in_acc = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
